// File: rtl/id_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage_pkg : RV32I decode constants, ID/EX entry type, imm helpers  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package id_stage_pkg;

  localparam int OPCODE_SIZE  = 7;
  localparam int FUNCT3_SIZE  = 3;
  localparam int FUNCT7_SIZE  = 7;
  localparam int WD_SIZE      = 32;
  localparam int REG_IDX_SIZE = 5;

  localparam logic [OPCODE_SIZE-1:0] OPCODE_OP = 7'b0110011;
  localparam logic [OPCODE_SIZE-1:0] OPCODE_IM = 7'b0010011;
  localparam logic [OPCODE_SIZE-1:0] OPCODE_LD = 7'b0000011;
  localparam logic [OPCODE_SIZE-1:0] OPCODE_ST = 7'b0100011;
  localparam logic [OPCODE_SIZE-1:0] OPCODE_BR = 7'b1100011;
  localparam logic [OPCODE_SIZE-1:0] OPCODE_JM = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_fmt_e;

  typedef struct packed {
    logic [OPCODE_SIZE-1:0]  opcode;
    logic [FUNCT3_SIZE-1:0]  funct3;
    logic [FUNCT7_SIZE-1:0]  funct7;
    logic [WD_SIZE-1:0]      op1;
    logic [WD_SIZE-1:0]      op2;
    logic [WD_SIZE-1:0]      imm;
    logic [WD_SIZE-1:0]      pc;
    logic [REG_IDX_SIZE-1:0] rd;
    logic                    we;
    logic                    illegal;
  } ex_entry_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [OPCODE_SIZE-1:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPCODE_IM, OPCODE_LD: fmt = IMM_I;
      OPCODE_ST:            fmt = IMM_S;
      OPCODE_BR:            fmt = IMM_B;
      OPCODE_JM:            fmt = IMM_J;
      default:              fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic [WD_SIZE-1:0] imm_gen(input logic [31:0] inst,
                                                  input imm_fmt_e    fmt);
    logic [WD_SIZE-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic is_legal(input logic [OPCODE_SIZE-1:0] opcode);
    return (opcode == OPCODE_OP) || (opcode == OPCODE_IM) || (opcode == OPCODE_LD) ||
           (opcode == OPCODE_ST) || (opcode == OPCODE_BR) || (opcode == OPCODE_JM);
  endfunction

  function automatic logic writes_rd(input logic [OPCODE_SIZE-1:0] opcode);
    return (opcode == OPCODE_OP) || (opcode == OPCODE_IM) ||
           (opcode == OPCODE_LD) || (opcode == OPCODE_JM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage_regfile : 2R/1W register file, async read, x0 hardwired 0   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module id_stage_regfile #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] raddr1_i,
  input  logic [IDX_W-1:0] raddr2_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);

  logic [WIDTH-1:0] regs_q [NREGS];

  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_regs
      if (i == 0) begin : g_zero
        assign regs_q[i] = '0;
      end else begin : g_reg
        always_ff @(posedge clk) begin
          if (reset) begin
            regs_q[i] <= '0;
          end else if (we_i && (waddr_i == IDX_W'(i))) begin
            regs_q[i] <= wdata_i;
          end
        end
      end
    end
  endgenerate

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage : RV32I decode/issue stage feeding the ID/EX register       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module id_stage
  import id_stage_pkg::*;
#(
  parameter int                 NREGS        = 32,
  parameter logic [WD_SIZE-1:0] RESET_PC_TAG = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inst_valid_i,
  output logic                    inst_ready_o,
  input  logic [31:0]             inst_i,
  input  logic [WD_SIZE-1:0]      pc_i,
  input  logic                    flush_i,
  input  logic                    wb_we_i,
  input  logic [REG_IDX_SIZE-1:0] wb_rd_i,
  input  logic [WD_SIZE-1:0]      wb_data_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [OPCODE_SIZE-1:0]  ex_opcode_o,
  output logic [FUNCT3_SIZE-1:0]  ex_funct3_o,
  output logic [FUNCT7_SIZE-1:0]  ex_funct7_o,
  output logic [WD_SIZE-1:0]      ex_op1_o,
  output logic [WD_SIZE-1:0]      ex_op2_o,
  output logic [WD_SIZE-1:0]      ex_imm_se_o,
  output logic [WD_SIZE-1:0]      ex_pc_o,
  output logic [REG_IDX_SIZE-1:0] ex_rd_o,
  output logic                    ex_we_o,
  output logic                    ex_illegal_o
);

  localparam int IDX_W = $clog2(NREGS);

  logic [OPCODE_SIZE-1:0]  w_opcode;
  logic [REG_IDX_SIZE-1:0] w_rs1;
  logic [REG_IDX_SIZE-1:0] w_rs2;
  logic [REG_IDX_SIZE-1:0] w_rd;
  logic [WD_SIZE-1:0]      w_rf_rdata1;
  logic [WD_SIZE-1:0]      w_rf_rdata2;
  logic [WD_SIZE-1:0]      w_rs1_data;
  logic [WD_SIZE-1:0]      w_rs2_data;
  logic                    w_byp1;
  logic                    w_byp2;
  logic                    w_accept;
  ex_entry_t               w_entry;

  logic                    ex_valid_q, ex_valid_d;
  ex_entry_t               ex_q, ex_d;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];

  id_stage_regfile #(
    .NREGS (NREGS),
    .WIDTH (WD_SIZE)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (w_rs1[IDX_W-1:0]),
    .raddr2_i (w_rs2[IDX_W-1:0]),
    .rdata1_o (w_rf_rdata1),
    .rdata2_o (w_rf_rdata2),
    .we_i     (wb_we_i),
    .waddr_i  (wb_rd_i[IDX_W-1:0]),
    .wdata_i  (wb_data_i)
  );

  // Same-cycle write-back beats the array, which only updates at the edge.
  assign w_byp1     = wb_we_i && (wb_rd_i != '0) && (wb_rd_i == w_rs1);
  assign w_byp2     = wb_we_i && (wb_rd_i != '0) && (wb_rd_i == w_rs2);
  assign w_rs1_data = w_byp1 ? wb_data_i : w_rf_rdata1;
  assign w_rs2_data = w_byp2 ? wb_data_i : w_rf_rdata2;

  assign inst_ready_o = !ex_valid_q || ex_ready_i;
  assign w_accept     = inst_valid_i && inst_ready_o && !flush_i;

  always_comb begin
    w_entry         = '0;
    w_entry.opcode  = w_opcode;
    w_entry.funct3  = inst_i[14:12];
    w_entry.funct7  = (w_opcode == OPCODE_OP) ? inst_i[31:25] : '0;
    w_entry.op1     = (w_opcode == OPCODE_JM) ? pc_i : w_rs1_data;
    w_entry.op2     = w_rs2_data;
    w_entry.imm     = imm_gen(inst_i, imm_fmt_of(w_opcode));
    w_entry.pc      = pc_i;
    w_entry.rd      = w_rd;
    w_entry.we      = writes_rd(w_opcode) && (w_rd != '0);
    w_entry.illegal = !is_legal(w_opcode);
  end

  // Payload only moves on accept, so a stalled entry is frozen by construction.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (w_accept) begin
      ex_valid_d = 1'b1;
      ex_d       = w_entry;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      ex_q.pc    <= RESET_PC_TAG;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_opcode_o  = ex_q.opcode;
  assign ex_funct3_o  = ex_q.funct3;
  assign ex_funct7_o  = ex_q.funct7;
  assign ex_op1_o     = ex_q.op1;
  assign ex_op2_o     = ex_q.op2;
  assign ex_imm_se_o  = ex_q.imm;
  assign ex_pc_o      = ex_valid_q ? ex_q.pc : RESET_PC_TAG;
  assign ex_rd_o      = ex_q.rd;
  assign ex_we_o      = ex_q.we;
  assign ex_illegal_o = ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_stage : scoreboard bench for the id_stage decode/issue stage   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [6:0]  ex_opcode_o;
  logic [2:0]  ex_funct3_o;
  logic [6:0]  ex_funct7_o;
  logic [31:0] ex_op1_o;
  logic [31:0] ex_op2_o;
  logic [31:0] ex_imm_se_o;
  logic [31:0] ex_pc_o;
  logic [4:0]  ex_rd_o;
  logic        ex_we_o;
  logic        ex_illegal_o;

  always #5 clk = ~clk;

  id_stage #(
    .NREGS        (32),
    .RESET_PC_TAG (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .inst_i       (inst_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .wb_we_i      (wb_we_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .ex_valid_o   (ex_valid_o),
    .ex_ready_i   (ex_ready_i),
    .ex_opcode_o  (ex_opcode_o),
    .ex_funct3_o  (ex_funct3_o),
    .ex_funct7_o  (ex_funct7_o),
    .ex_op1_o     (ex_op1_o),
    .ex_op2_o     (ex_op2_o),
    .ex_imm_se_o  (ex_imm_se_o),
    .ex_pc_o      (ex_pc_o),
    .ex_rd_o      (ex_rd_o),
    .ex_we_o      (ex_we_o),
    .ex_illegal_o (ex_illegal_o)
  );

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t r_mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [4:0] rd, input logic we, input logic ill);
    exp_t e;
    e.opc = opc; e.f3 = f3; e.f7 = f7; e.op1 = op1; e.op2 = op2;
    e.imm = imm; e.pc = pc; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Flushed entries are killed, consumed entries are compared.
  always @(negedge clk) begin
    if (!reset && ex_valid_o && (flush_i || ex_ready_i)) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        r_mon_e = sb.pop_front();
        if (!flush_i) begin
          check_eq("opcode",  ex_opcode_o,  r_mon_e.opc);
          check_eq("funct3",  ex_funct3_o,  r_mon_e.f3);
          check_eq("funct7",  ex_funct7_o,  r_mon_e.f7);
          check_eq("op1",     ex_op1_o,     r_mon_e.op1);
          check_eq("op2",     ex_op2_o,     r_mon_e.op2);
          check_eq("imm",     ex_imm_se_o,  r_mon_e.imm);
          check_eq("pc",      ex_pc_o,      r_mon_e.pc);
          check_eq("rd",      ex_rd_o,      r_mon_e.rd);
          check_eq("we",      ex_we_o,      r_mon_e.we);
          check_eq("illegal", ex_illegal_o, r_mon_e.ill);
        end
      end
    end
  end

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    wb_we_i = 1'b1; wb_rd_i = rd; wb_data_i = data;
    @(posedge clk); #1;
    wb_we_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    int n;
    inst_valid_i = 1'b1; inst_i = inst; pc_i = pc;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (inst_ready_o && !flush_i) break;
      n++;
      if (n > 20) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    if (n <= 20) sb.push_back(e);
    @(posedge clk); #1;
    inst_valid_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inst_valid_i = 1'b0; inst_i = '0; pc_i = '0; flush_i = 1'b0;
    wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; ex_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_eq("rst_valid",   ex_valid_o,   32'd0);
    check_eq("rst_pc",      ex_pc_o,      32'h0);
    check_eq("rst_op1",     ex_op1_o,     32'h0);
    check_eq("rst_imm",     ex_imm_se_o,  32'h0);
    check_eq("rst_we",      ex_we_o,      32'd0);
    check_eq("rst_illegal", ex_illegal_o, 32'd0);
    check_eq("rst_ready",   inst_ready_o, 32'd1);
    @(posedge clk); #1;

    wb_write(5'd5, 32'h0000_0010);
    wb_write(5'd6, 32'h0000_0003);

    // SUB x7,x5,x6
    send(32'h406283B3, 32'h0, mk(7'h33, 3'd0, 7'h20, 32'd16, 32'd3, 32'd0, 32'h0, 5'd7, 1'b1, 1'b0));
    // ADDI x1,x0,-1 and the rd=0 variant
    send(32'hFFF00093, 32'h4, mk(7'h13, 3'd0, 7'h00, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h4, 5'd1, 1'b1, 1'b0));
    send(32'hFFF00013, 32'h8, mk(7'h13, 3'd0, 7'h00, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8, 5'd0, 1'b0, 1'b0));

    // ADD x8,x5,x5 with same-cycle write-back of x5
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
    send(32'h00528433, 32'hC, mk(7'h33, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 32'hC, 5'd8, 1'b1, 1'b0));
    wb_we_i = 1'b0;

    // Stall the ADD while ADDI x2,x0,5 is offered; x5 is rewritten during the stall
    ex_ready_i = 1'b0;
    inst_valid_i = 1'b1; inst_i = 32'h00500113; pc_i = 32'h10;
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h0000_1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stall_ready", inst_ready_o, 32'd0);
      check_eq("stall_valid", ex_valid_o,   32'd1);
      check_eq("stall_rd",    ex_rd_o,      32'd8);
      check_eq("stall_op1",   ex_op1_o,     32'hDEAD_BEEF);
      check_eq("stall_op2",   ex_op2_o,     32'hDEAD_BEEF);
      @(posedge clk); #1;
      wb_we_i = 1'b0;
    end
    ex_ready_i = 1'b1;
    send(32'h00500113, 32'h10, mk(7'h13, 3'd0, 7'h00, 32'd0, 32'h0000_1234, 32'd5, 32'h10, 5'd2, 1'b1, 1'b0));

    // JAL x1,+8 ; BEQ x0,x0,-4 ; SW x6,8(x5) ; LW x3,-8(x6)
    send(32'h008000EF, 32'h100, mk(7'h6F, 3'd0, 7'h00, 32'h100, 32'd0, 32'd8, 32'h100, 5'd1, 1'b1, 1'b0));
    send(32'hFE000EE3, 32'h104, mk(7'h63, 3'd0, 7'h00, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h104, 5'd29, 1'b0, 1'b0));
    send(32'h0062A423, 32'h108, mk(7'h23, 3'd2, 7'h00, 32'h0000_1234, 32'd3, 32'd8, 32'h108, 5'd8, 1'b0, 1'b0));
    send(32'hFF832183, 32'h10C, mk(7'h03, 3'd2, 7'h00, 32'd3, 32'd0, 32'hFFFF_FFF8, 32'h10C, 5'd3, 1'b1, 1'b0));

    // Flush kills the in-flight ADDI x4 and drops the offered ADDI x9
    send(32'h00100213, 32'h40, mk(7'h13, 3'd0, 7'h00, 32'd0, 32'd0, 32'd1, 32'h40, 5'd4, 1'b1, 1'b0));
    inst_valid_i = 1'b1; inst_i = 32'h00100493; pc_i = 32'h44; flush_i = 1'b1;
    @(negedge clk);
    check_eq("flush_ready", inst_ready_o, 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b0; inst_valid_i = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", ex_valid_o, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("flush_drop", ex_valid_o, 32'd0);
    @(posedge clk); #1;

    // Unsupported opcode with rd=10
    send(32'h0000057F, 32'h50, mk(7'h7F, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'h50, 5'd10, 1'b0, 1'b1));

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
